// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// The arbiter grants at most one port per cycle and drives the shared ALU with
// that port's operands. Results and flags are captured into a per-port
// response register, which is held until the requester accepts it.
// Contention is round-robin by default. Define ALU_ARB_FIXED_PRIO_EN to make
// port 0 always win; port 1 can then starve.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_A,
  input  logic [DATA_WIDTH-1:0] req0_B,
  input  logic [2:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_A,
  input  logic [DATA_WIDTH-1:0] req1_B,
  input  logic [2:0]            req1_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_result,
  output logic [2:0]            rsp0_flags,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_result,
  output logic [2:0]            rsp1_flags,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero
);

  logic elig0, elig1;
  logic grant0, grant1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  // 1 means port 1 won most recently, so port 0 is preferred next.
  logic last_grant;
`endif

  // Eligibility and grant selection. A response slot that is being drained
  // in this cycle counts as free. No grant is given while in reset.
  always_comb begin
    elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant0 = ~rst & elig0;
    grant1 = ~rst & elig1 & ~elig0;
`else
    grant0 = ~rst & elig0 & (~elig1 | last_grant);
    grant1 = ~rst & elig1 & (~elig0 | ~last_grant);
`endif
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Shared ALU input mux. Port 0 is the idle default so the ALU inputs are never X.
  always_comb begin
    alu_A  = req0_A;
    alu_B  = req0_B;
    alu_op = req0_op;
    if (grant1) begin
      alu_A  = req1_A;
      alu_B  = req1_B;
      alu_op = req1_op;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer. It holds its value in cycles without a grant.
  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (grant0) last_grant <= 1'b0;
    else if (grant1) last_grant <= 1'b1;
  end
`endif

  // Port 0 response register. A new capture takes precedence over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
    end else if (grant0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_Result;
      rsp0_flags  <= {alu_Overflow, alu_CarryOut, alu_Zero};
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  // Port 1 response register. A new capture takes precedence over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else if (grant1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_Result;
      rsp1_flags  <= {alu_Overflow, alu_CarryOut, alu_Zero};
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter. A reference ALU model answers the DUT's shared
// ALU port. Expected responses are queued per port when a grant is seen and
// are compared when the response register updates.
module tb_alu_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic [2:0]    rsp0_flags, rsp1_flags;
  logic [DW-1:0] alu_A, alu_B, alu_Result;
  logic [2:0]    alu_op;
  logic          alu_Overflow, alu_CarryOut, alu_Zero;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [2:0]    flags;
  } exp_t;

  typedef struct {
    int            port;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [DW-1:0] res;
    logic [2:0]    flags;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[10];

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow), .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {Overflow, CarryOut, Zero, Result}. CarryOut on SUB is a borrow.
  function automatic logic [DW+2:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          ov, c;
    r = '0; ov = 1'b0; c = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[DW-1:0];
        c  = s[DW];
        ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'b110: begin
        r  = a - b;
        c  = (a < b);
        ov = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'b111: r = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      default: r = '0;
    endcase
    return {ov, c, (r == '0), r};
  endfunction

  // Combinational reference ALU attached to the shared port.
  always_comb begin
    logic [DW+2:0] m;
    m = alu_model(alu_A, alu_B, alu_op);
    alu_Result   = m[DW-1:0];
    alu_Zero     = m[DW];
    alu_CarryOut = m[DW+1];
    alu_Overflow = m[DW+2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [2:0] op);
    if (port == 0) begin
      req0_valid = v; req0_A = a; req0_B = b; req0_op = op;
    end else begin
      req1_valid = v; req1_A = a; req1_B = b; req1_op = op;
    end
  endtask

  function automatic logic get_ready(input int port);
    return (port == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic push_exp(input int port, input logic [DW-1:0] res, input logic [2:0] flags);
    exp_t e;
    e.res = res;
    e.flags = flags;
    if (port == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic pop_check(input int port, input string name);
    exp_t e;
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty for port %0d", name, port);
      return;
    end
    if (port == 0) begin
      e = q0.pop_front();
      check({name, "_valid"}, rsp0_valid, 1'b1);
      check({name, "_result"}, rsp0_result, e.res);
      check({name, "_flags"}, rsp0_flags, e.flags);
    end else begin
      e = q1.pop_front();
      check({name, "_valid"}, rsp1_valid, 1'b1);
      check({name, "_result"}, rsp1_result, e.res);
      check({name, "_flags"}, rsp1_flags, e.flags);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_port;
    int w;

    vecs[0] = '{0, 32'd5,          32'd7,          3'b010, 32'd12,         3'b000};
    vecs[1] = '{1, 32'h7FFF_FFFF,  32'd1,          3'b010, 32'h8000_0000,  3'b100};
    vecs[2] = '{0, 32'd3,          32'd3,          3'b110, 32'd0,          3'b001};
    vecs[3] = '{1, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'd1,          3'b000};
    vecs[4] = '{0, 32'h0000_F0F0,  32'h0000_FF00,  3'b000, 32'h0000_F000,  3'b000};
    vecs[5] = '{1, 32'h0000_000F,  32'h0000_00F0,  3'b001, 32'h0000_00FF,  3'b000};
    vecs[6] = '{0, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          3'b011};
    vecs[7] = '{1, 32'd1,          32'd2,          3'b110, 32'hFFFF_FFFF,  3'b010};
    vecs[8] = '{0, 32'd5,          32'd7,          3'b011, 32'd0,          3'b001};
    vecs[9] = '{0, 32'd1,          32'hFFFF_FFFF,  3'b111, 32'd0,          3'b001};

    // Hold reset for 2 cycles with both requesters valid.
    rst = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd2, 3'b010);
    set_req(1, 1'b1, 32'd3, 32'd4, 3'b010);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check("rst_req0_ready", req0_ready, 1'b0);
      check("rst_req1_ready", req1_ready, 1'b0);
      check("rst_rsp0_valid", rsp0_valid, 1'b0);
      check("rst_rsp1_valid", rsp1_valid, 1'b0);
      check("rst_rsp0_result", rsp0_result, '0);
      check("rst_rsp1_result", rsp1_result, '0);
    end

    // Contention directly after reset. Both ports are valid for 4 cycles.
    rst = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd3, 3'b110);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = i % 2;
`endif
      check("cont_grant", {req1_ready, req0_ready}, (exp_port == 0) ? 2'b01 : 2'b10);
      if (exp_port == 0) push_exp(0, 32'd0, 3'b001);
      else push_exp(1, 32'd1, 3'b000);
      tick();
      pop_check(exp_port, "cont_rsp");
    end
    set_req(0, 1'b0, 32'd0, 32'd0, 3'b000);
    set_req(1, 1'b0, 32'd0, 32'd0, 3'b000);
    tick();

    // Table of single-port operations.
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].port, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      w = 0;
      while (!get_ready(vecs[i].port) && w < 4) begin
        @(posedge clk);
        #2;
        w++;
      end
      check("tbl_grant", get_ready(vecs[i].port), 1'b1);
      check("tbl_other_idle", get_ready(1 - vecs[i].port), 1'b0);
      if (get_ready(vecs[i].port)) begin
        push_exp(vecs[i].port, vecs[i].res, vecs[i].flags);
        tick();
        pop_check(vecs[i].port, "tbl_rsp");
      end else begin
        tick();
      end
      set_req(vecs[i].port, 1'b0, '0, '0, 3'b000);
      tick();
    end

    // Back-to-back issue on port 0 at one op per cycle while draining every cycle.
    for (int i = 1; i <= 3; i++) begin
      set_req(0, 1'b1, i, i, 3'b010);
      #1;
      check("b2b_grant", req0_ready, 1'b1);
      push_exp(0, 2 * i, 3'b000);
      tick();
      pop_check(0, "b2b_rsp");
    end
    set_req(0, 1'b0, '0, '0, 3'b000);
    tick();

    // Backpressure on port 1.
    rsp1_ready = 1'b0;
    set_req(1, 1'b1, 32'd1, 32'd2, 3'b010);
    #1;
    check("bp_first_grant", req1_ready, 1'b1);
    push_exp(1, 32'd3, 3'b000);
    tick();
    pop_check(1, "bp_first_rsp");
    set_req(1, 1'b1, 32'h10, 32'h01, 3'b001);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_ready", req1_ready, 1'b0);
      check("bp_hold_valid", rsp1_valid, 1'b1);
      check("bp_hold_result", rsp1_result, 32'd3);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("bp_release_grant", req1_ready, 1'b1);
    push_exp(1, 32'h11, 3'b000);
    tick();
    pop_check(1, "bp_release_rsp");
    set_req(1, 1'b0, '0, '0, 3'b000);
    tick();
    check("bp_drain", rsp1_valid, 1'b0);

    // Reset one cycle after a port 0 grant.
    rsp0_ready = 1'b0;
    set_req(0, 1'b1, 32'd4, 32'd4, 3'b010);
    #1;
    check("mrst_grant", req0_ready, 1'b1);
    tick();
    check("mrst_pre_valid", rsp0_valid, 1'b1);
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, 3'b000);
    tick();
    check("mrst_valid", rsp0_valid, 1'b0);
    check("mrst_result", rsp0_result, '0);
    rst = 1'b0;
    rsp0_ready = 1'b1;
    set_req(0, 1'b1, 32'hF, 32'h3, 3'b000);
    set_req(1, 1'b1, 32'hF, 32'h3, 3'b001);
    #1;
    check("mrst_prio", {req1_ready, req0_ready}, 2'b01);
    push_exp(0, 32'h3, 3'b000);
    tick();
    pop_check(0, "mrst_rsp");
    set_req(0, 1'b0, '0, '0, 3'b000);
    set_req(1, 1'b0, '0, '0, 3'b000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
